// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the core's instruction-fetch port (i_*)
// and its data port (d_*). The data side wins ties. A fetch that has waited
// through DATA_BURST_MAX consecutive data grants is served next. A grant that
// sees no mem_valid for TIMEOUT cycles is aborted with a bus_error pulse.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   i_request/i_we_re/i_mask/i_addr          fetch request side (held until i_valid)
//   i_valid/i_rdata              fetch completion (combinational from mem_valid)
//   d_request/d_we_re/d_mask/d_addr/d_wdata  data request side (held until d_valid)
//   d_valid/d_rdata              data completion (combinational from mem_valid)
//   mem_request/mem_we_re/mem_mask/mem_addr/mem_wdata  registered memory request
//   mem_valid/mem_rdata          memory completion (single-cycle pulse)
//   bus_error                    single-cycle pulse when an access is aborted by timeout
//
// Cycle flow: IDLE decides -> GNT_x (mem_request high) -> TURN (one dead cycle
// so the finished requester can drop its request) -> IDLE.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT        = 64,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_request,
  input  logic        i_we_re,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_request,
  input  logic        d_we_re,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  localparam int unsigned BW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(DATA_BURST_MAX);
  localparam logic [BW-1:0]   BURST_ONE = BW'(1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST   = (TIMEOUT > 32'd0) ? TO_W'(TIMEOUT - 32'd1) : {TO_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            mem_request_q, mem_request_d;
  logic            mem_we_re_q, mem_we_re_d;
  logic [3:0]      mem_mask_q, mem_mask_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic            grant_s;
  logic            timeout_hit_s;
  logic            done_s;

  // Grant status, timeout detection (mem_valid in the last cycle still wins)
  always_comb begin
    grant_s       = (state_q == GNT_I) || (state_q == GNT_D);
    timeout_hit_s = 1'b0;
    if (TIMEOUT != 32'd0) begin
      timeout_hit_s = grant_s && (to_q == TO_LAST) && !mem_valid;
    end else begin
      timeout_hit_s = 1'b0;
    end
    done_s = grant_s && (mem_valid || timeout_hit_s);
  end

  // Completion outputs; rdata is zero on abort because mem_valid is low then
  always_comb begin
    i_valid   = 1'b0;
    i_rdata   = 32'h0000_0000;
    d_valid   = 1'b0;
    d_rdata   = 32'h0000_0000;
    bus_error = timeout_hit_s;
    if (state_q == GNT_I) begin
      i_valid = done_s;
      i_rdata = mem_valid ? mem_rdata : 32'h0000_0000;
    end else if (state_q == GNT_D) begin
      d_valid = done_s;
      d_rdata = mem_valid ? mem_rdata : 32'h0000_0000;
    end else begin
      i_valid = 1'b0;
      d_valid = 1'b0;
    end
  end

  // Next-state, starvation counter, timeout counter and latched memory fields
  always_comb begin
    state_d       = state_q;
    burst_d       = burst_q;
    to_d          = to_q;
    mem_request_d = mem_request_q;
    mem_we_re_d   = mem_we_re_q;
    mem_mask_d    = mem_mask_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        // Data wins unless the pending fetch has sat through a full data burst
        if (d_request && !(i_request && (burst_q == BURST_MAX))) begin
          state_d       = GNT_D;
          to_d          = {TO_W{1'b0}};
          mem_request_d = 1'b1;
          mem_we_re_d   = d_we_re;
          mem_mask_d    = d_mask;
          mem_addr_d    = d_addr;
          mem_wdata_d   = d_wdata;
          if (!i_request) begin
            burst_d = {BW{1'b0}};
          end else if (burst_q == BURST_MAX) begin
            burst_d = burst_q;
          end else begin
            burst_d = burst_q + BURST_ONE;
          end
        end else if (i_request) begin
          state_d       = GNT_I;
          to_d          = {TO_W{1'b0}};
          burst_d       = {BW{1'b0}};
          mem_request_d = 1'b1;
          mem_we_re_d   = i_we_re;
          mem_mask_d    = i_mask;
          mem_addr_d    = i_addr;
          mem_wdata_d   = 32'h0000_0000;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (done_s) begin
          state_d       = TURN;
          mem_request_d = 1'b0;
          mem_we_re_d   = 1'b0;
          mem_mask_d    = 4'h0;
          mem_addr_d    = 32'h0000_0000;
          mem_wdata_d   = 32'h0000_0000;
        end else if (TIMEOUT != 32'd0) begin
          to_d = to_q + TO_ONE;
        end else begin
          to_d = to_q;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        mem_request_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      burst_q       <= {BW{1'b0}};
      to_q          <= {TO_W{1'b0}};
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_mask_q    <= 4'h0;
      mem_addr_q    <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      to_q          <= to_d;
      mem_request_q <= mem_request_d;
      mem_we_re_q   <= mem_we_re_d;
      mem_mask_q    <= mem_mask_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_request = mem_request_q;
  assign mem_we_re   = mem_we_re_q;
  assign mem_mask    = mem_mask_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a cycle table for fetch-only, simultaneous
// request and stray mem_valid cases, then hand sequences for starvation,
// timeout and reset mid-grant. Inputs change 1 time unit after the rising
// edge; outputs are checked 5 time units after the rising edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_request, i_we_re;
  logic [3:0]  i_mask;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_request, d_we_re;
  logic [3:0]  d_mask;
  logic [31:0] d_addr, d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_request, mem_we_re;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DATA_BURST_MAX(4), .TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_we_re(i_we_re), .i_mask(i_mask), .i_addr(i_addr),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic [31:0] i_adr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wd;
    logic        mv;
    logic [31:0] mr;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iv;
    logic [31:0] e_ir;
    logic        e_dv;
    logic [31:0] e_dr;
    logic        e_be;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    int nst;
    int order[$];
    int exp_order[7];
    logic seen_i;
    logic seen_d;

    // inputs: i_req i_adr d_req d_we d_adr d_wd mv mr | exp: req we addr wdata iv ir dv dr be
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00500093, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h00500093, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0};
    vecs[9]  = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[12] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};

    exp_order = '{1, 1, 1, 1, 0, 1, 1};

    rst = 1'b1;
    i_request = 1'b0; i_we_re = 1'b0; i_mask = 4'hF; i_addr = 32'h0;
    d_request = 1'b0; d_we_re = 1'b0; d_mask = 4'hF; d_addr = 32'h0; d_wdata = 32'h0;
    mem_valid = 1'b0; mem_rdata = 32'h0;

    // Reset state
    tick();
    tick();
    #4;
    chk("rst_mem_req", {31'b0, mem_request}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_i_valid", {31'b0, i_valid}, 32'd0);
    chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
    chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
    tick();
    rst = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < 16; i++) begin
      i_request = vecs[i].i_req;  i_addr = vecs[i].i_adr;
      d_request = vecs[i].d_req;  d_we_re = vecs[i].d_we;
      d_addr = vecs[i].d_adr;     d_wdata = vecs[i].d_wd;
      mem_valid = vecs[i].mv;     mem_rdata = vecs[i].mr;
      #4;
      chk($sformatf("v%0d_mem_req", i), {31'b0, mem_request}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we_re}, {31'b0, vecs[i].e_we});
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_mem_mask", i), {28'b0, mem_mask}, 32'hF);
      end
      chk($sformatf("v%0d_i_valid", i), {31'b0, i_valid}, {31'b0, vecs[i].e_iv});
      chk($sformatf("v%0d_i_rdata", i), i_rdata, vecs[i].e_ir);
      chk($sformatf("v%0d_d_valid", i), {31'b0, d_valid}, {31'b0, vecs[i].e_dv});
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_dr);
      chk($sformatf("v%0d_bus_error", i), {31'b0, bus_error}, {31'b0, vecs[i].e_be});
      tick();
    end
    mem_valid = 1'b0;

    // Starvation: 6 stores back to back with a fetch pending from the start
    gcnt = 0; nst = 6;
    i_request = 1'b1; i_addr = 32'h108;
    d_request = 1'b1; d_we_re = 1'b1; d_addr = 32'h400; d_wdata = 32'h0BAD_F00D;
    for (int cyc = 0; cyc < 200 && order.size() < 7; cyc++) begin
      mem_valid = 1'b0;
      if (mem_request) begin
        gcnt++;
        if (gcnt == 2) begin
          mem_valid = 1'b1;
          mem_rdata = 32'hA5A5_0000 + 32'(cyc);
        end
      end else begin
        gcnt = 0;
      end
      #4;
      seen_i = i_valid;
      seen_d = d_valid;
      if (seen_d) begin
        order.push_back(1);
        nst--;
      end
      if (seen_i) order.push_back(0);
      tick();
      if (seen_d) begin
        if (nst == 0) d_request = 1'b0;
        else d_addr = d_addr + 32'd4;
      end
      if (seen_i) i_request = 1'b0;
    end
    mem_valid = 1'b0;
    chk("starve_len", 32'(order.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < order.size()) chk($sformatf("starve_grant%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end

    // Timeout: load with no mem_valid aborts on the 8th grant cycle
    d_request = 1'b0; i_request = 1'b0;
    tick();
    d_request = 1'b1; d_we_re = 1'b0; d_addr = 32'h300; mem_rdata = 32'hFFFF_FFFF;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #4;
      chk($sformatf("to%0d_mem_req", k), {31'b0, mem_request}, 32'd1);
      chk($sformatf("to%0d_d_valid", k), {31'b0, d_valid}, (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("to%0d_bus_error", k), {31'b0, bus_error}, (k == 8) ? 32'd1 : 32'd0);
      if (k == 8) chk("to8_d_rdata", d_rdata, 32'h0);
      tick();
    end
    d_request = 1'b0;
    #4;
    chk("to_turn_mem_req", {31'b0, mem_request}, 32'd0);
    chk("to_turn_bus_error", {31'b0, bus_error}, 32'd0);
    tick();

    // Next access: mem_valid in the last allowed cycle completes normally
    d_request = 1'b1; d_addr = 32'h304;
    tick();
    for (int k = 1; k <= 8; k++) begin
      mem_valid = (k == 8);
      mem_rdata = 32'h55AA_55AA;
      #4;
      chk($sformatf("late%0d_d_valid", k), {31'b0, d_valid}, (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("late%0d_bus_error", k), {31'b0, bus_error}, 32'd0);
      if (k == 8) chk("late8_d_rdata", d_rdata, 32'h55AA_55AA);
      if (k == 1) chk("late1_mem_addr", mem_addr, 32'h304);
      tick();
    end
    mem_valid = 1'b0; d_request = 1'b0;
    tick();

    // Reset in the second data grant cycle, fetch still held
    i_request = 1'b1; i_addr = 32'h500;
    d_request = 1'b1; d_we_re = 1'b1; d_addr = 32'h600;
    tick();
    #4;
    chk("rg_mem_req", {31'b0, mem_request}, 32'd1);
    chk("rg_mem_we", {31'b0, mem_we_re}, 32'd1);
    tick();
    rst = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h7777_7777; d_request = 1'b0;
    #1;
    chk("rg_rst_mem_req", {31'b0, mem_request}, 32'd0);
    chk("rg_rst_d_valid", {31'b0, d_valid}, 32'd0);
    chk("rg_rst_i_valid", {31'b0, i_valid}, 32'd0);
    chk("rg_rst_bus_error", {31'b0, bus_error}, 32'd0);
    tick();
    rst = 1'b0; mem_valid = 1'b0;
    tick();
    #4;
    chk("rg_fetch_req", {31'b0, mem_request}, 32'd1);
    chk("rg_fetch_we", {31'b0, mem_we_re}, 32'd0);
    chk("rg_fetch_addr", mem_addr, 32'h500);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
